sa_writeback_ctrl: RTL

// - Parametrised write-back stage behind the systolic-array pooling outputs. Replaces the fixed per-SA address regs.
// - Per channel: captures pooled beats and generates SRAM write addresses (h-mode or v-mode), then buffers {addr,data} in a FIFO.
// - Round-robin merges all channels onto one valid/ready SRAM write port, with backpressure and overflow flags.

---
 rtl/sa_wb_pkg.sv | 28 ++
 rtl/sa_wb_fifo.sv | 55 +++++
 rtl/sa_writeback_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sa_wb_pkg.sv
// Shared types and helpers for the systolic-array write-back stage.
// Lane select assumes DIM <= WB_LANE_MAX.
package sa_wb_pkg;

  localparam int WB_ADDR_W   = 10;
  localparam int WB_DATA_W   = 16;
  localparam int WB_LANE_MAX = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_HMODE = 1'b0,
    WB_VMODE = 1'b1
  } wb_mode_e;

  function automatic logic [4:0] wb_lane_sel(
    input logic [WB_LANE_MAX-1:0] en
  );
    wb_lane_sel = '0;
    for (int k = WB_LANE_MAX - 1; k >= 0; k--) begin
      if (en[k]) wb_lane_sel = 5'(k);
    end
  endfunction

endpackage

// File: rtl/sa_wb_fifo.sv
// Per-channel entry FIFO; push and pop may coincide, even when full.
// DEPTH must be a power of two, >= 2.
module sa_wb_fifo
  import sa_wb_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   push_i,
  input  entry_t din_i,
  input  logic   pop_i,
  output entry_t dout_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot the push needs in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rp_q];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop)  rp_q <= rp_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din_i;
  end

endmodule

// File: rtl/sa_writeback_ctrl.sv
// Write-back stage: per-SA address generation, FIFOs, round-robin SRAM port.
// Optional perf counters: define SA_WB_PERF_CNT_EN. Requires SA_NUM >= 2.
module sa_writeback_ctrl
  import sa_wb_pkg::*;
#(
  parameter int SA_NUM     = 4,
  parameter int DIM        = 4,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cfg_set,
  input  logic                          cfg_vmode,
  input  logic [$clog2(SA_NUM):0]       cfg_sa_num,
  input  logic [ADDR_W-1:0]             cfg_base_addr,
  input  logic [SA_NUM*DIM-1:0]         pool_rd_en,
  input  logic [SA_NUM*DIM*DATA_W-1:0]  pool_data,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [$clog2(SA_NUM)-1:0]     wr_src,
  output logic [SA_NUM-1:0]             ovf_flag,
  output logic                          busy,
  output logic [31:0]                   stall_cnt,
  output logic [15:0]                   drop_cnt
);

  localparam int SW = $clog2(SA_NUM);
  localparam int CW = SW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  wb_mode_e          mode_q;
  logic [CW-1:0]     num_q;
  logic [ADDR_W-1:0] max_q;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] base_q [SA_NUM];
  logic [ADDR_W-1:0] base_d [SA_NUM];
  logic [ADDR_W-1:0] cnt_q  [SA_NUM];
  logic [ADDR_W-1:0] cnt_d  [SA_NUM];
  logic [4:0]        sel    [SA_NUM];
  ent_t              din    [SA_NUM];
  ent_t              dout   [SA_NUM];
  logic [SA_NUM-1:0] act;
  logic [SA_NUM-1:0] push;
  logic [SA_NUM-1:0] pop;
  logic [SA_NUM-1:0] drop;
  logic [SA_NUM-1:0] full;
  logic [SA_NUM-1:0] empty;
  logic [SA_NUM-1:0] ovf_q;
  logic [SW-1:0]     rr_q;
  logic [SW-1:0]     gnt_q;
  logic [SW-1:0]     gnt;
  logic              lock_q;
  logic              fire;

  assign step = (mode_q == WB_VMODE) ? ADDR_W'(DIM)
                                     : max_q * ADDR_W'(num_q);

  always_comb begin
    for (int i = 0; i < SA_NUM; i++) begin
      if (mode_q == WB_HMODE) act[i] = (CW'(i) < num_q);
      else                    act[i] = (num_q == CW'(i + 1));
      sel[i]      = wb_lane_sel(WB_LANE_MAX'(pool_rd_en[i*DIM +: DIM]));
      push[i]     = |pool_rd_en[i*DIM +: DIM] && act[i] && !cfg_set;
      din[i].addr = base_q[i] + cnt_q[i];
      din[i].data = pool_data[(i*DIM + int'(sel[i]))*DATA_W +: DATA_W];
    end
  end

  // Addresses advance on every accepted beat, dropped or not.
  always_comb begin
    for (int i = 0; i < SA_NUM; i++) begin
      base_d[i] = base_q[i];
      cnt_d[i]  = cnt_q[i];
      if (cfg_set) begin
        cnt_d[i] = '0;
        if (!cfg_vmode)
          base_d[i] = cfg_base_addr
                    + ADDR_W'(i * int'(cfg_sa_num) * DIM);
        else if (cfg_sa_num == CW'(i + 1))
          base_d[i] = cfg_base_addr;
      end else if (push[i]) begin
        if (max_q != '0 && (cnt_q[i] + 1'b1) == max_q) begin
          cnt_d[i]  = '0;
          base_d[i] = base_q[i] + step;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // A stalled grant stays locked until the SRAM accepts it.
  always_comb begin
    gnt = rr_q;
    if (lock_q) begin
      gnt = gnt_q;
    end else begin
      for (int k = SA_NUM - 1; k >= 0; k--) begin
        if (!empty[(int'(rr_q) + k) % SA_NUM])
          gnt = SW'((int'(rr_q) + k) % SA_NUM);
      end
    end
  end

  assign wr_valid = !empty[gnt];
  assign wr_addr  = dout[gnt].addr;
  assign wr_data  = dout[gnt].data;
  assign wr_src   = gnt;
  assign fire     = wr_valid && wr_ready;
  assign busy     = ~&empty;
  assign ovf_flag = ovf_q;

  always_comb begin
    for (int i = 0; i < SA_NUM; i++)
      pop[i] = fire && (gnt == SW'(i));
  end

  always_comb begin
    for (int i = 0; i < SA_NUM; i++)
      drop[i] = push[i] && full[i] && !pop[i];
  end

  for (genvar g = 0; g < SA_NUM; g++) begin : g_fifo
    sa_wb_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (ent_t)
    ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (push[g]),
      .din_i   (din[g]),
      .pop_i   (pop[g]),
      .dout_o  (dout[g]),
      .full_o  (full[g]),
      .empty_o (empty[g])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q <= WB_HMODE;
      num_q  <= '0;
      max_q  <= '0;
      ovf_q  <= '0;
      rr_q   <= '0;
      gnt_q  <= '0;
      lock_q <= 1'b0;
      for (int i = 0; i < SA_NUM; i++) begin
        base_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      if (cfg_set) begin
        mode_q <= wb_mode_e'(cfg_vmode);
        num_q  <= cfg_sa_num;
        max_q  <= cfg_vmode ? ADDR_W'(DIM)
                            : ADDR_W'(int'(cfg_sa_num) * DIM);
        ovf_q  <= '0;
      end else begin
        ovf_q  <= ovf_q | drop;
      end
      for (int i = 0; i < SA_NUM; i++) begin
        base_q[i] <= base_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      lock_q <= wr_valid && !wr_ready;
      gnt_q  <= gnt;
      if (fire)
        rr_q <= (gnt == SW'(SA_NUM - 1)) ? '0 : gnt + 1'b1;
    end
  end

`ifdef SA_WB_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [15:0] drop_q;
  logic [15:0] drop_d;

  always_comb begin
    drop_d = drop_q;
    for (int i = 0; i < SA_NUM; i++) begin
      if (drop[i] && drop_d != 16'hFFFF) drop_d = drop_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else if (cfg_set) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      if (wr_valid && !wr_ready) stall_q <= stall_q + 1'b1;
      drop_q <= drop_d;
    end
  end

  assign stall_cnt = stall_q;
  assign drop_cnt  = drop_q;
`else
  assign stall_cnt = '0;
  assign drop_cnt  = '0;
`endif

endmodule
